// File: rtl/wt_arb_pkg.sv
//------------------------------------------------------------------------------
// wt_arb_pkg : shared types for the write-through memory arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wt_arb_pkg;

  localparam int unsigned ARB_TID_W = 3;
  localparam int unsigned ARB_CNT_W = 4;
  localparam int unsigned ARB_NREQ  = 2;

  typedef struct packed {
    logic [ARB_TID_W-1:0] tid;
    logic [55:0]          paddr;
    logic [2:0]           size;
    logic [2:0]           rtype;
    logic                 nc;
    logic [63:0]          data;
  } arb_req_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Saturating increment keeps an over-subscribed counter pinned at all-ones.
  function automatic logic [ARB_CNT_W-1:0] cnt_sat_inc(input logic [ARB_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [ARB_CNT_W-1:0] cnt_floor_dec(input logic [ARB_CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wt_arb_rr2.sv
//------------------------------------------------------------------------------
// wt_arb_rr2 : two-way round-robin selector, purely combinational
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wt_arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic       vld_o,
  output logic       gnt_o
);

  // prio_i names the favoured requester; it only matters under contention.
  always_comb begin
    vld_o = |req_i;
    gnt_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = prio_i;
    end else begin
      gnt_o = req_i[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/wt_mem_arbiter.sv
//------------------------------------------------------------------------------
// wt_mem_arbiter : icache/dcache arbiter towards one memory adapter with
// return routing; define WT_ARB_CREDIT_LIMIT_EN to enable credit limiting.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wt_mem_arbiter
  import wt_arb_pkg::*;
#(
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned IcacheTxId     = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           req_i,
  input  arb_req_t [1:0]       req_data_i,
  output logic [1:0]           ack_o,
  output logic                 mem_req_o,
  output arb_req_t             mem_data_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rtrn_vld_i,
  input  logic [ARB_TID_W-1:0] mem_rtrn_tid_i,
  output logic [1:0]           rtrn_vld_o,
  output logic                 busy_o,
  output logic                 err_o
);

  if (NumOutstanding < 1 || NumOutstanding > 15) begin : g_bad_cfg
    $error("wt_mem_arbiter: NumOutstanding must be in 1..15");
  end

  localparam logic [ARB_TID_W-1:0] IcacheTid = ARB_TID_W'(IcacheTxId);

  arb_state_e                 state_q, state_d;
  logic                       gnt_q, gnt_d;
  logic                       prio_q, prio_d;
  logic [1:0][ARB_CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0] elig;
  logic       rr_vld;
  logic       rr_gnt;
  logic       cur_gnt;
  logic       mem_req;
  logic       ack_vld;
  logic       rtrn_vld;
  logic       tid_hit;

  for (genvar i = 0; i < ARB_NREQ; i++) begin : g_elig
`ifdef WT_ARB_CREDIT_LIMIT_EN
    assign elig[i] = req_i[i] & (cnt_q[i] < ARB_CNT_W'(NumOutstanding));
`else
    assign elig[i] = req_i[i];
`endif
  end

  wt_arb_rr2 u_rr (
    .req_i  (elig),
    .prio_i (prio_q),
    .vld_o  (rr_vld),
    .gnt_o  (rr_gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    mem_req = 1'b0;
    cur_gnt = gnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (rr_vld) begin
          mem_req = 1'b1;
          cur_gnt = rr_gnt;
          if (!mem_ack_i) begin
            state_d = ARB_LOCKED;
            gnt_d   = rr_gnt;
          end
        end
      end
      ARB_LOCKED: begin
        mem_req = 1'b1;
        if (mem_ack_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    if (mem_req && mem_ack_i) begin
      prio_d = ~cur_gnt;
    end
  end

  // Combinational outputs are gated by rst_ni so they clear the moment reset asserts.
  assign mem_req_o  = mem_req & rst_ni;
  assign mem_data_o = req_data_i[cur_gnt];
  assign ack_vld    = mem_req_o & mem_ack_i;
  assign ack_o      = {ack_vld & cur_gnt, ack_vld & ~cur_gnt};

  assign rtrn_vld   = mem_rtrn_vld_i & rst_ni;
  assign tid_hit    = (mem_rtrn_tid_i == IcacheTid);
  assign rtrn_vld_o = {rtrn_vld & ~tid_hit, rtrn_vld & tid_hit};

  assign err_o = rst_ni & ((mem_ack_i & ~mem_req)
                         | (rtrn_vld_o[0] & (cnt_q[0] == '0))
                         | (rtrn_vld_o[1] & (cnt_q[1] == '0)));

  assign busy_o = (state_q == ARB_LOCKED) | (|cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < ARB_NREQ; i++) begin
      case ({ack_o[i], rtrn_vld_o[i]})
        2'b10:   cnt_d[i] = cnt_sat_inc(cnt_q[i]);
        2'b01:   cnt_d[i] = cnt_floor_dec(cnt_q[i]);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire
